// File: rtl/fft_bitrev_buffer.sv
// fft_bitrev_buffer
// Absorbs one 4096-sample frame (1024 beats x 4 lanes) and streams it back
// in 12-bit bit-reversed order (BITREV=1) or natural order (BITREV=0).
// Storage is four single-port banks. Sample n lives in bank
// (n[1:0] + n[11:10]) mod 4 at address n[11:2]. With this skew, each input
// beat and each output beat touches all four banks exactly once.
module fft_bitrev_buffer #(
    parameter int DW     = 64,
    parameter bit BITREV = 1'b1
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          START,
    input  logic [DW-1:0] D0,
    input  logic [DW-1:0] D1,
    input  logic [DW-1:0] D2,
    input  logic [DW-1:0] D3,
    output logic          DONE,
    output logic [DW-1:0] Q0,
    output logic [DW-1:0] Q1,
    output logic [DW-1:0] Q2,
    output logic [DW-1:0] Q3
);

    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        TAIL  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   k_q, k_d;          // input beat counter
    logic [AW-1:0]   m_q, m_d;          // output beat counter
    logic            wr_en;
    logic            rd_en;

    // Lane skew latched with each read so the output crossbar lines up with
    // the data returned by the banks one cycle later.
    logic [1:0]      rot_q, rot_d;
    // Keeps Q at zero until the first read after reset. This lets the bank
    // read registers stay free of reset.
    logic            valid_q, valid_d;

    logic [DW-1:0]   d_lane      [4];
    logic [DW-1:0]   wr_data     [4];
    logic [AW-1:0]   rd_addr     [4];
    logic [DW-1:0]   bank_rdata  [4];
    logic [DW-1:0]   q_lane      [4];
    logic [1:0]      wr_rot;
    logic [1:0]      rd_rot;

    function automatic logic [1:0] rev2(input logic [1:0] x);
        return {x[0], x[1]};
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) begin
            r[b] = x[7-b];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------

    // State and beat counter registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            k_q     <= '0;
            m_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            m_q     <= m_d;
        end
    end

    // Next-state, counter update and RAM enables.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        m_d     = m_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                k_d = '0;
                m_d = '0;
                if (START) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                wr_en = 1'b1;
                k_d   = k_q + 10'd1;
                if (k_q == 10'd1023) begin
                    state_d = DRAIN;
                    k_d     = '0;
                    m_d     = '0;
                end
            end
            DRAIN: begin
                rd_en = 1'b1;
                m_d   = m_q + 10'd1;
                if (m_q == 10'd1023) begin
                    state_d = TAIL;
                    m_d     = '0;
                end
            end
            TAIL: begin
                state_d = IDLE;
                k_d     = '0;
                m_d     = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign DONE = (state_q == DRAIN);

    // ------------------------------------------------------------------
    // Skew terms
    // ------------------------------------------------------------------
    // Write side: sample 4k+i goes to bank (i + k[9:8]) mod 4.
    assign wr_rot = k_q[9:8];

    // Read side: for BITREV=1 the source sample of lane j is
    // {rev2(j), rev10(m)}. Its low two bits are rev2(m[9:8]). So lane j sits
    // in bank (rev2(j) + rev2(m[9:8])) mod 4. For natural order, lane j sits
    // in bank (j + m[9:8]) mod 4.
    assign rd_rot = BITREV ? rev2(m_q[9:8]) : m_q[9:8];

    // Output skew and valid flag, updated only when a read is issued.
    always_comb begin
        rot_d   = rot_q;
        valid_d = valid_q;
        if (rd_en) begin
            rot_d   = rd_rot;
            valid_d = 1'b1;
        end
    end

    // Output skew / valid registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rot_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            rot_q   <= rot_d;
            valid_q <= valid_d;
        end
    end

    assign d_lane[0] = D0;
    assign d_lane[1] = D1;
    assign d_lane[2] = D2;
    assign d_lane[3] = D3;

    // ------------------------------------------------------------------
    // Banks with write crossbar and per-bank read address generation
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            localparam logic [1:0] GI2 = 2'(gi);

            logic [DW-1:0] mem [DEPTH];
            logic [DW-1:0] rdata_q;
            logic [1:0]    wr_sel;
            logic [1:0]    rd_t;

            // Bank gi is written by the input lane whose skewed bank equals gi.
            assign wr_sel      = GI2 - wr_rot;
            assign wr_data[gi] = d_lane[wr_sel];

            // In bit-reversed mode, the lane read from bank gi has
            // rev2(lane) = gi - rd_rot. Its address is {rev2(lane), rev10(m)[9:2]}.
            assign rd_t        = GI2 - rd_rot;
            assign rd_addr[gi] = BITREV ? {rd_t, rev8(m_q[7:0])} : m_q;

            // Single-port bank: write during LOAD, registered read during DRAIN.
            always_ff @(posedge CLK) begin
                if (wr_en) begin
                    mem[k_q] <= wr_data[gi];
                end
                if (rd_en) begin
                    rdata_q <= mem[rd_addr[gi]];
                end
            end

            assign bank_rdata[gi] = rdata_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read crossbar: output lane gi picks the bank holding its sample
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] GI2      = 2'(gi);
            localparam logic [1:0] LANE_SRC = BITREV ? {GI2[0], GI2[1]} : GI2;

            logic [1:0] src_bank;

            assign src_bank   = LANE_SRC + rot_q;
            assign q_lane[gi] = valid_q ? bank_rdata[src_bank] : '0;
        end
    endgenerate

    assign Q0 = q_lane[0];
    assign Q1 = q_lane[1];
    assign Q2 = q_lane[2];
    assign Q3 = q_lane[3];

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Testbench for fft_bitrev_buffer: a bit-reversing instance, a natural-order
// instance on the same inputs, and a second bit-reversing instance chained
// behind the first. Outputs are compared with an array-based reference model.
module tb_fft_bitrev_buffer;

    localparam int DW = 64;
    localparam int NS = 4096;
    localparam int NB = 1024;

    typedef logic [DW-1:0] word_q_t[$];

    typedef struct {
        int          m;
        int          j;
        logic [DW-1:0] exp;
    } spot_t;

    logic          clk   = 1'b0;
    logic          rstn  = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] d  [4];
    logic [DW-1:0] q1 [4];
    logic [DW-1:0] q0 [4];
    logic [DW-1:0] q2 [4];
    logic          done1, done0, done2;

    always #5 clk = ~clk;

    fft_bitrev_buffer #(.DW(DW), .BITREV(1'b1)) dut (
        .CLK(clk), .RSTn(rstn), .START(start),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .DONE(done1),
        .Q0(q1[0]), .Q1(q1[1]), .Q2(q1[2]), .Q3(q1[3])
    );

    fft_bitrev_buffer #(.DW(DW), .BITREV(1'b0)) u_nat (
        .CLK(clk), .RSTn(rstn), .START(start),
        .D0(d[0]), .D1(d[1]), .D2(d[2]), .D3(d[3]),
        .DONE(done0),
        .Q0(q0[0]), .Q1(q0[1]), .Q2(q0[2]), .Q3(q0[3])
    );

    fft_bitrev_buffer #(.DW(DW), .BITREV(1'b1)) u_chain (
        .CLK(clk), .RSTn(rstn), .START(done1),
        .D0(q1[0]), .D1(q1[1]), .D2(q1[2]), .D3(q1[3]),
        .DONE(done2),
        .Q0(q2[0]), .Q1(q2[1]), .Q2(q2[2]), .Q3(q2[3])
    );

    // Sinks: take Q in every cycle that follows a DONE-high cycle.
    word_q_t cap1, cap0, cap2;
    bit dp1 = 1'b0, dp0 = 1'b0, dp2 = 1'b0;
    always @(negedge clk) begin
        if (dp1) for (int j = 0; j < 4; j++) cap1.push_back(q1[j]);
        if (dp0) for (int j = 0; j < 4; j++) cap0.push_back(q0[j]);
        if (dp2) for (int j = 0; j < 4; j++) cap2.push_back(q2[j]);
        dp1 = done1;
        dp0 = done0;
        dp2 = done2;
    end

    // Reference model
    logic [DW-1:0] frame     [NS];
    logic [DW-1:0] exp_br    [NS];
    logic [DW-1:0] exp_nat   [NS];
    logic [DW-1:0] exp_chain [NS];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int rev12(input int p);
        int r = 0;
        for (int b = 0; b < 12; b++) begin
            if (((p >> b) & 1) != 0) r |= (1 << (11 - b));
        end
        return r;
    endfunction

    task automatic build_model();
        for (int p = 0; p < NS; p++) begin
            exp_br[p]  = frame[rev12(p)];
            exp_nat[p] = frame[p];
        end
        for (int p = 0; p < NS; p++) begin
            exp_chain[p] = exp_br[rev12(p)];
        end
    endtask

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_capture(input string name, input word_q_t capq, input int which);
        int            bad   = 0;
        int            first = -1;
        int            lim;
        logic [DW-1:0] e;
        logic [DW-1:0] g_first = '0;
        logic [DW-1:0] e_first = '0;
        check_int({name, "_len"}, capq.size(), NS);
        lim = (capq.size() < NS) ? capq.size() : NS;
        for (int p = 0; p < lim; p++) begin
            e = (which == 0) ? exp_nat[p] : (which == 1) ? exp_br[p] : exp_chain[p];
            if (capq[p] !== e) begin
                if (first < 0) begin
                    first   = p;
                    g_first = capq[p];
                    e_first = e;
                end
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: %0d wrong samples, first at p=%0d got %h expected %h",
                     name, bad, first, g_first, e_first);
        end else begin
            $display("frame %s: %0d samples match", name, lim);
        end
    endtask

    task automatic idle_check(input string tag, input int ncyc);
        int hi = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (done1) hi++;
            @(posedge clk); #1;
        end
        check_int(tag, hi, 0);
    endtask

    // One full frame through the DUT. The bench starts 1 after an edge with
    // the DUT in IDLE and returns 1 after E2049.
    task automatic run_frame(input string tag, input int kind, input logic [DW-1:0] offset,
                             input bit toggle, input bit keep_start, input bit expect_q_zero);
        int hi_load  = 0;
        int hi_drain = 0;
        for (int n = 0; n < NS; n++) begin
            frame[n] = (kind == 0) ? (DW'(n) + offset) : {$urandom(), $urandom()};
        end
        build_model();
        cap1.delete();
        cap0.delete();
        cap2.delete();
        start = 1'b1;
        @(posedge clk); #1;                       // E0
        start = keep_start;
        for (int k = 0; k < NB; k++) begin
            for (int i = 0; i < 4; i++) d[i] = frame[4*k + i];
            if (done1) hi_load++;
            if (toggle) start = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        // Now 1 after E1024: DRAIN has started but Q is not yet updated.
        if (expect_q_zero) begin
            check({tag, "_q_before_E1025"}, q1[0] | q1[1] | q1[2] | q1[3], '0);
        end
        for (int m = 0; m < NB; m++) begin
            if (done1) hi_drain++;
            if (toggle) start = 1'($urandom_range(0, 1));
            for (int i = 0; i < 4; i++) d[i] = {$urandom(), $urandom()};
            @(posedge clk); #1;
        end
        // 1 after E2048: TAIL, beat 1023 on Q.
        check_int({tag, "_done_in_load"}, hi_load, 0);
        check_int({tag, "_done_cycles"}, hi_drain, NB);
        check_int({tag, "_done_fall"}, done1, 0);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("%s_q_last_lane%0d", tag, j), q1[j], exp_br[4*(NB-1) + j]);
        end
        start = keep_start;
        @(posedge clk); #1;                       // 1 after E2049, IDLE
        check_int({tag, "_done_idle"}, done1, 0);
        check({tag, "_q_hold_tail"}, q1[3], exp_br[NS-1]);
        check_capture({tag, "_bitrev"}, cap1, 1);
        check_capture({tag, "_natural"}, cap0, 0);
    endtask

    // Start a frame and stop after ncyc edges past E0, feeding ramp data.
    task automatic partial(input int ncyc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            if (c < NB) for (int i = 0; i < 4; i++) d[i] = DW'(4*c + i) + 64'h7000;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    spot_t spots [12];

    initial begin
        // Expected ramp beats for BITREV=1 (from the sample-ordering rules).
        spots[0]  = '{0,    0, 64'h000};
        spots[1]  = '{0,    1, 64'h800};
        spots[2]  = '{0,    2, 64'h400};
        spots[3]  = '{0,    3, 64'hC00};
        spots[4]  = '{1,    0, 64'h200};
        spots[5]  = '{1,    1, 64'hA00};
        spots[6]  = '{1,    2, 64'h600};
        spots[7]  = '{1,    3, 64'hE00};
        spots[8]  = '{1023, 0, 64'h3FF};
        spots[9]  = '{1023, 1, 64'hBFF};
        spots[10] = '{1023, 2, 64'h7FF};
        spots[11] = '{1023, 3, 64'hFFF};

        for (int i = 0; i < 4; i++) d[i] = '0;
        rstn = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_int("reset_done", done1, 0);
        check("reset_q", q1[0] | q1[1] | q1[2] | q1[3], '0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Ramp: one-cycle START pulse, then START toggled during LOAD/DRAIN.
        run_frame("ramp", 0, '0, 1'b1, 1'b0, 1'b1);
        idle_check("ramp_single_frame", 1100);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("ramp_q_hold_lane%0d", j), q1[j], 64'(spots[8 + j].exp));
        end
        for (int s = 0; s < 12; s++) begin
            check($sformatf("ramp_spot_m%0d_j%0d", spots[s].m, spots[s].j),
                  cap1[4*spots[s].m + spots[s].j], spots[s].exp);
        end
        check_capture("chain_restore", cap2, 2);

        // Back-to-back frames with START held high.
        run_frame("rand_b2b", 1, '0, 1'b0, 1'b1, 1'b0);
        run_frame("offset_b2b", 0, 64'h1000, 1'b0, 1'b0, 1'b0);

        // Reset in LOAD at k=500.
        partial(500);
        rstn = 1'b0;
        #1;
        check_int("rst_load_done", done1, 0);
        check("rst_load_q", q1[0] | q1[1] | q1[2] | q1[3], '0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle_check("rst_load_no_done", 1100);

        // Reset in DRAIN at m=300.
        partial(NB + 300);
        check_int("rst_drain_active", done1, 1);
        rstn = 1'b0;
        #1;
        check_int("rst_drain_done", done1, 0);
        check("rst_drain_q", q1[0] | q1[1] | q1[2] | q1[3], '0);
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle_check("rst_drain_no_done", 1100);

        // Fresh random frame after reset.
        run_frame("fresh", 1, '0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_buffer.md
# fft_bitrev_buffer

Frame buffer that takes the responder side of the START/DONE four-lane streaming protocol used around the FFT core `TOP`. It absorbs one 4096-sample frame delivered as 1024 beats of four samples. It then streams the frame back under DONE, in bit-reversed (or natural) order. It sits directly in front of, or behind, the FFT datapath and converts between natural-order and bit-reversed-order sample streams.

## Interface
- DW, 64: sample width (packed complex word).
- BITREV, 1: 1 = output in 12-bit bit-reversed order; 0 = natural order.
- CLK  input  1  clock.
- RSTn  input  1  reset; asynchronous, active-low.
- START  input  1  frame request; sampled only in IDLE.
- D0..D3  input  DW each  input beat k, lane i = sample n = 4k+i.
- DONE  output  1  high for exactly 1024 consecutive cycles while the frame is read out.
- Q0..Q3  output  DW each  output beat m, lane j = output position p = 4m+j; registered.

## Operation
- Storage: 4 banks of 1024×DW, single port per bank. Write and read phases never overlap.
- Bank of sample n: (n[1:0] + n[11:10]) mod 4. Address within bank: n[11:2]. This skew makes every input beat and every output beat touch four distinct banks.
- The source sample for output position p is rev12(p) when BITREV=1, else p.
  - rev12 maps bit b to bit 11−b.
  - For BITREV=1: n = {rev2(j), rev10(m)}.
- Lane-to-bank routing uses 4:1 crossbars on the write side and the read side, steered by the same skew.
- FSM states:
  - IDLE: DONE=0. On an edge with START=1, go to LOAD and clear beat counter k.
  - LOAD: capture D0..D3 as beat k at every edge; k increments. At the edge that captures k=1023, go to DRAIN and clear m. Inputs after beat 1023 are ignored; the source may hold or repeat data.
  - DRAIN: DONE=1 and read beat m is issued each cycle. After the cycle with m=1023, go to TAIL.
  - TAIL: DONE=0 for one cycle while beat 1023 is on Q; then go to IDLE.
- START is ignored outside IDLE. If START is still high in IDLE, a new frame starts immediately.
- Counters k and m are 10 bits and do not wrap within a frame. Both are cleared on every state entry.
- Reset (any time, including mid-LOAD or mid-DRAIN): state=IDLE, DONE=0, Q0..Q3=0, counters=0. A partial frame is abandoned and RAM contents are don't-care.
- Q holds the last beat after TAIL until the next DRAIN overwrites it.

## Timing
- Let E0 be the edge where START=1 is sampled in IDLE.
- Input beat k is captured at edge E(k+1). Beat 0 must be on D in the cycle after E0.
- DONE is high from E1024 to E2048 (1024 cycles).
- Q beat m is registered at edge E(1025+m), so Q lags DONE by one cycle. Q is stable in the cycle after the DONE cycle that issued beat m.
  - A sink that registers Q on each edge where it has seen DONE high captures beats 0..1023 exactly.
- TAIL occupies E2048–E2049; IDLE is entered at E2049.
- Back-to-back frames: minimum START-to-START period is 2050 cycles.
- RAM read latency is exactly 1 cycle. No combinational path exists from D to Q or from START to DONE.

## Test plan
- Ramp, BITREV=1: D sample n = n (0x000..0xFFF), START held high.
  - Output beat 0 = {0x000, 0x800, 0x400, 0xC00}.
  - Beat 1 = {0x200, 0xA00, 0x600, 0xE00}.
  - Beat 1023 = {0x3FF, 0xBFF, 0x7FF, 0xFFF}.
  - DONE is high for exactly 1024 cycles.
- Ramp, BITREV=0: beat m = {4m, 4m+1, 4m+2, 4m+3}. Apply bit-reverse twice through two instances and check the original ramp is restored.
- Timing check: count cycles from E0. DONE rises after E1024 and falls after E2048. Q is 0 before E1025 and equals beat 1023 from E2048 until the next frame.
- START pulsed for one cycle, then toggled during LOAD and DRAIN: exactly one frame is produced and the toggles are ignored.
- START held high across frames: the second frame's LOAD begins at E2049+1. Data with a 0x1000 offset returns correctly with no stale first-frame samples.
- Reset mid-operation:
  - Assert RSTn=0 at beat k=500 of LOAD: DONE=0 and Q=0 immediately (asynchronous). After release, no DONE appears until START.
  - Assert RSTn=0 at DRAIN m=300: same behaviour.
  - A fresh frame after release is output correctly.
